// File: rtl/cai_submit_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cai_submit_sched
//
// Schedules CAI submit-ring work from NUM_CTX contexts onto a single shared
// CAI execution engine. Each context owns a ring with a producer index (tail,
// advanced by host doorbells) and a consumer index (head, advanced when the
// engine retires a descriptor). Contexts are picked round-robin; exactly one
// descriptor is in flight at any time.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ctx_enable          per-context scheduling enable
//   ctx_clear           pulse: clear sticky halt/overflow flags
//   submit_doorbell     pulse: one new descriptor on that ring
//   ctx_submit_base     packed 64-bit submit ring base address per context
//   ctx_comp_base       packed 64-bit completion ring base address per context
//   disp_valid/ready    dispatch handshake towards the engine
//   disp_ctx            context of the dispatched descriptor
//   disp_desc_addr      descriptor byte address
//   disp_comp_addr      completion record byte address
//   done_valid/status   engine completion of the in-flight descriptor
//   comp_msg            one-cycle retire pulse per context
//   ctx_head            packed consumer index per context
//   ctx_halt            sticky: context stopped after an error completion
//   ctx_overflow        sticky: doorbell dropped because the ring was full
//   busy                scheduler is not idle
// -----------------------------------------------------------------------------
module cai_submit_sched #(
  parameter int NUM_CTX     = 4,
  parameter int RING_LOG2   = 4,
  parameter int DESC_STRIDE = 64,
  parameter int COMP_STRIDE = 16,
  localparam int CTX_W      = $clog2(NUM_CTX),
  localparam int IDX_W      = RING_LOG2 + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CTX-1:0]       ctx_enable,
  input  logic [NUM_CTX-1:0]       ctx_clear,
  input  logic [NUM_CTX-1:0]       submit_doorbell,
  input  logic [NUM_CTX*64-1:0]    ctx_submit_base,
  input  logic [NUM_CTX*64-1:0]    ctx_comp_base,
  output logic                     disp_valid,
  input  logic                     disp_ready,
  output logic [CTX_W-1:0]         disp_ctx,
  output logic [63:0]              disp_desc_addr,
  output logic [63:0]              disp_comp_addr,
  input  logic                     done_valid,
  input  logic [15:0]              done_status,
  output logic [NUM_CTX-1:0]       comp_msg,
  output logic [NUM_CTX*IDX_W-1:0] ctx_head,
  output logic [NUM_CTX-1:0]       ctx_halt,
  output logic [NUM_CTX-1:0]       ctx_overflow,
  output logic                     busy
);

  localparam int                DESC_SHIFT = $clog2(DESC_STRIDE);
  localparam int                COMP_SHIFT = $clog2(COMP_STRIDE);
  localparam logic [IDX_W-1:0]  RING_DEPTH = IDX_W'(1 << RING_LOG2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_WAIT,
    S_RETIRE
  } state_t;

  // Ring indices carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W-1:0]     r_tail [NUM_CTX];
  logic [IDX_W-1:0]     r_head [NUM_CTX];

  state_t               r_state;
  state_t               w_state_nxt;

  logic [NUM_CTX-1:0]   w_pending;
  logic [NUM_CTX-1:0]   w_full;
  logic [NUM_CTX-1:0]   w_elig_now;
  logic [NUM_CTX-1:0]   r_elig;
  logic [NUM_CTX-1:0]   w_cand;

  logic [CTX_W-1:0]     r_grant;
  logic [CTX_W-1:0]     r_rr_ptr;
  logic [CTX_W-1:0]     w_pick;
  logic                 w_pick_valid;
  logic [RING_LOG2-1:0] w_pick_slot;

  logic [63:0]          r_desc_addr;
  logic [63:0]          r_comp_addr;
  logic [63:0]          w_desc_addr;
  logic [63:0]          w_comp_addr;
  logic [15:0]          r_status;

  logic [NUM_CTX-1:0]   r_comp_msg;
  logic [NUM_CTX-1:0]   r_halt;
  logic [NUM_CTX-1:0]   r_overflow;

  logic                 w_grant_en;
  logic                 w_capture;
  logic                 w_retire;

  // ---------------------------------------------------------------------------
  // Per-context ring status
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CTX; g++) begin : g_ctx
    assign w_pending[g]  = (r_tail[g] != r_head[g]);
    assign w_full[g]     = ((r_tail[g] - r_head[g]) == RING_DEPTH);
    assign w_elig_now[g] = ctx_enable[g] & w_pending[g] & ~r_halt[g];
    assign ctx_head[g*IDX_W +: IDX_W] = r_head[g];
  end

  // A context must look eligible both in the registered snapshot and right now.
  // The snapshot is wiped while retiring, so the ring that just retired is
  // re-evaluated with its updated head before it can be granted again.
  assign w_cand = r_elig & w_elig_now;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first candidate searching cyclically from rr_ptr+1
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is
    // inferred when no candidate is found.
    w_pick       = '0;
    w_pick_valid = 1'b0;
    for (int off = 1; off <= NUM_CTX; off++) begin
      if (!w_pick_valid && w_cand[(int'(r_rr_ptr) + off) % NUM_CTX]) begin
        w_pick       = CTX_W'((int'(r_rr_ptr) + off) % NUM_CTX);
        w_pick_valid = 1'b1;
      end
    end
  end

  // Addresses for the picked context, latched only at grant time.
  assign w_pick_slot = r_head[w_pick][RING_LOG2-1:0];
  assign w_desc_addr = ctx_submit_base[int'(w_pick)*64 +: 64] + (64'(w_pick_slot) << DESC_SHIFT);
  assign w_comp_addr = ctx_comp_base[int'(w_pick)*64 +: 64]   + (64'(w_pick_slot) << COMP_SHIFT);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    disp_valid  = 1'b0;
    busy        = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_grant_en  = 1'b1;
          w_state_nxt = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        disp_valid = 1'b1;
        if (disp_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RETIRE;
        end
      end
      S_RETIRE: begin
        w_retire    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: grant/address latch, completion capture, rings and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elig      <= '0;
      r_grant     <= '0;
      r_rr_ptr    <= CTX_W'(NUM_CTX - 1);
      r_desc_addr <= '0;
      r_comp_addr <= '0;
      r_status    <= '0;
      r_comp_msg  <= '0;
      r_halt      <= '0;
      r_overflow  <= '0;
      // NOTE: the index arrays are reset because their contents are
      // architectural state (ring pointers), not scratch storage.
      for (int i = 0; i < NUM_CTX; i++) begin
        r_tail[i] <= '0;
        r_head[i] <= '0;
      end
    end else begin
      r_comp_msg <= '0;
      r_elig     <= (r_state == S_RETIRE) ? '0 : w_elig_now;

      if (w_grant_en) begin
        r_grant     <= w_pick;
        r_rr_ptr    <= w_pick;
        r_desc_addr <= w_desc_addr;
        r_comp_addr <= w_comp_addr;
      end

      if (w_capture) begin
        r_status <= done_status;
      end

      for (int i = 0; i < NUM_CTX; i++) begin
        // Full check uses pre-edge indices: a same-cycle retire does not
        // make room for this doorbell.
        if (submit_doorbell[i] && !w_full[i]) begin
          r_tail[i] <= r_tail[i] + 1'b1;
        end

        if (w_retire && (r_grant == CTX_W'(i))) begin
          r_head[i]     <= r_head[i] + 1'b1;
          r_comp_msg[i] <= 1'b1;
        end

        // Set has priority over clear for both sticky flags.
        if (w_retire && (r_grant == CTX_W'(i)) && (r_status != 16'd0)) begin
          r_halt[i] <= 1'b1;
        end else if (ctx_clear[i]) begin
          r_halt[i] <= 1'b0;
        end

        if (submit_doorbell[i] && w_full[i]) begin
          r_overflow[i] <= 1'b1;
        end else if (ctx_clear[i]) begin
          r_overflow[i] <= 1'b0;
        end
      end
    end
  end

  assign disp_ctx       = r_grant;
  assign disp_desc_addr = r_desc_addr;
  assign disp_comp_addr = r_comp_addr;
  assign comp_msg       = r_comp_msg;
  assign ctx_halt       = r_halt;
  assign ctx_overflow   = r_overflow;

endmodule
